// File: rtl/arbitro_rr4_pkg.sv
// Shared definitions for the four-class weighted round-robin scheduler.
//   NUM_VC      : number of input FIFOs (virtual channels)
//   DATA_W_DEF  : default FIFO word width
//   BURST_DEF   : default max consecutive grants to one requester
//   vc_idx_t    : index of one input FIFO
//   grant_t     : selector result (valid + index)
package arbitro_rr4_pkg;

  localparam int unsigned NUM_VC     = 4;
  localparam int unsigned VC_W       = 2;
  localparam int unsigned DATA_W_DEF = 12;
  localparam int unsigned BURST_DEF  = 2;

  typedef logic [VC_W-1:0] vc_idx_t;

  typedef struct packed {
    logic    valid;
    vc_idx_t idx;
  } grant_t;

endpackage

// File: rtl/arbitro_rr4_select.sv
// Combinational round-robin selector for four requesters.
//   i_elig      : eligible mask (bit i = FIFO i may be popped this edge)
//   i_last      : index of the most recent grant
//   i_exhausted : last requester has used its whole burst
//   o_grant_c   : chosen index plus valid bit (combinational)
module rr_select4
  import arbitro_rr4_pkg::*;
(
  input  logic [NUM_VC-1:0] i_elig,
  input  vc_idx_t           i_last,
  input  logic              i_exhausted,
  output grant_t            o_grant_c
);

  vc_idx_t w_cand;

  // Keep the last winner while its burst lasts; otherwise scan from last+1.
  // The scan runs offsets 4 down to 1 so the nearest eligible index wins;
  // offset 4 wraps to the last winner itself, which restarts its burst.
  always_comb begin
    o_grant_c = '0;
    w_cand    = i_last;
    if (i_elig[i_last] && !i_exhausted) begin
      o_grant_c.valid = 1'b1;
      o_grant_c.idx   = i_last;
    end else begin
      for (int off = NUM_VC; off >= 1; off--) begin
        w_cand = vc_idx_t'(i_last + vc_idx_t'(off));
        if (i_elig[w_cand]) begin
          o_grant_c.valid = 1'b1;
          o_grant_c.idx   = w_cand;
        end
      end
    end
  end

endmodule

// File: rtl/arbitro_rr4.sv
// Weighted round-robin scheduler from four input FIFOs to one output FIFO.
//   clk, reset      : clock, synchronous active-high reset
//   active          : enable; 0 stops new pops
//   emptyFIFO       : empty flag per input FIFO
//   almost_fullFIFO : output FIFO back-pressure
//   datain          : registered read data, FIFO i at [i*DATA_W +: DATA_W]
//   pop             : one-hot pop strobe (registered)
//   push, dataout   : write to output FIFO, one cycle after the pop
//   idle            : scheduler quiescent
module arbitro_rr4
  import arbitro_rr4_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned BURST  = BURST_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     active,
  input  logic [NUM_VC-1:0]        emptyFIFO,
  input  logic                     almost_fullFIFO,
  input  logic [NUM_VC*DATA_W-1:0] datain,
  output logic [NUM_VC-1:0]        pop,
  output logic                     push,
  output logic [DATA_W-1:0]        dataout,
  output logic                     idle
);

  localparam int unsigned CNT_W = $clog2(BURST + 1);

  logic [NUM_VC-1:0] r_pop;
  logic [NUM_VC-1:0] w_pop_nxt;
  logic [NUM_VC-1:0] w_elig;
  logic              r_push;
  logic              w_push_nxt;
  logic              r_idle;
  logic              w_idle_nxt;
  logic [DATA_W-1:0] r_dout;
  logic [DATA_W-1:0] w_dout_nxt;
  logic [DATA_W-1:0] w_rd_word;
  vc_idx_t           r_last;
  vc_idx_t           w_last_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_exhausted;
  logic              w_stay;
  grant_t            w_grant;

  // Nobody is eligible while disabled or while the output FIFO is near full.
  assign w_elig      = (active && !almost_fullFIFO) ? ~emptyFIFO : '0;
  assign w_exhausted = (r_cnt >= CNT_W'(BURST));
  assign w_stay      = w_elig[r_last] && !w_exhausted;

  // r_last doubles as the registered index of the word popped last cycle.
  assign w_rd_word = datain[32'(r_last) * DATA_W +: DATA_W];

  rr_select4 u_select (
    .i_elig      (w_elig),
    .i_last      (r_last),
    .i_exhausted (w_exhausted),
    .o_grant_c   (w_grant)
  );

  // Next grant, burst bookkeeping, one-cycle data pipe and idle status.
  always_comb begin
    w_pop_nxt  = '0;
    w_last_nxt = r_last;
    w_cnt_nxt  = r_cnt;
    w_push_nxt = |r_pop;
    w_dout_nxt = r_dout;
    if (|r_pop) begin
      w_dout_nxt = w_rd_word;
    end
    if (w_grant.valid) begin
      w_pop_nxt[w_grant.idx] = 1'b1;
      w_last_nxt             = w_grant.idx;
      w_cnt_nxt              = w_stay ? (r_cnt + CNT_W'(1)) : CNT_W'(1);
    end
    // Idle looks at the values pop/push take at this same edge.
    w_idle_nxt = active && (&emptyFIFO) && (w_pop_nxt == '0) && !w_push_nxt;
  end

  // State and output registers; reset drops any in-flight word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pop  <= '0;
      r_push <= 1'b0;
      r_dout <= '0;
      r_idle <= 1'b0;
      r_last <= '0;
      r_cnt  <= '0;
    end else begin
      r_pop  <= w_pop_nxt;
      r_push <= w_push_nxt;
      r_dout <= w_dout_nxt;
      r_idle <= w_idle_nxt;
      r_last <= w_last_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign pop     = r_pop;
  assign push    = r_push;
  assign dataout = r_dout;
  assign idle    = r_idle;

endmodule

// File: tb/tb_arbitro_rr4.sv
// Self-checking bench for arbitro_rr4 with a registered-read input FIFO model
// and a scoreboard of expected output words (filled when words are loaded,
// in the order the arbiter is expected to forward them).
module tb_arbitro_rr4;
  import arbitro_rr4_pkg::*;

  localparam int unsigned DW = 12;
  localparam int unsigned NV = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            active;
  logic [NV-1:0]   emptyFIFO;
  logic            almost_fullFIFO;
  logic [NV*DW-1:0] datain;
  logic [NV-1:0]   pop;
  logic            push;
  logic [DW-1:0]   dataout;
  logic            idle;

  int n_pass  = 0;
  int n_total = 0;

  // Input FIFO model
  logic [DW-1:0] mem [NV][16];
  logic [DW-1:0] rd  [NV];
  int            cnt [NV];
  int            hd  [NV];
  logic [DW-1:0] sb  [$];
  logic [DW-1:0] last_out;

  always #5 clk = ~clk;

  arbitro_rr4 #(.DATA_W(DW), .BURST(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .active          (active),
    .emptyFIFO       (emptyFIFO),
    .almost_fullFIFO (almost_fullFIFO),
    .datain          (datain),
    .pop             (pop),
    .push            (push),
    .dataout         (dataout),
    .idle            (idle)
  );

  always_comb begin
    emptyFIFO = '0;
    datain    = '0;
    for (int v = 0; v < NV; v++) begin
      emptyFIFO[v]         = (cnt[v] == 0);
      datain[v*DW +: DW]   = rd[v];
    end
  end

  task automatic clear_model();
    for (int v = 0; v < NV; v++) begin
      cnt[v] = 0;
      hd[v]  = 0;
      rd[v]  = '0;
    end
    sb.delete();
  endtask

  task automatic load(input int v, input logic [DW-1:0] w);
    mem[v][hd[v] + cnt[v]] = w;
    cnt[v]++;
    sb.push_back(w);
  endtask

  // Advance one edge; FIFOs act on the pop decided at that edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int v = 0; v < NV; v++) begin
      if (pop[v] === 1'b1 && cnt[v] > 0) begin
        rd[v] = mem[v][hd[v]];
        hd[v]++;
        cnt[v]--;
      end
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
    last_out = '0;
  endtask

  task automatic test_reset();
    active = 1'b1; almost_fullFIFO = 1'b0; clear_model();
    reset = 1'b1; tick(); tick();
    n_total++; if (pop !== 4'b0000) $display("FAIL rst_pop got %b want 0000", pop); else n_pass++;
    n_total++; if (push !== 1'b0) $display("FAIL rst_push got %b want 0", push); else n_pass++;
    n_total++; if (dataout !== 12'h000) $display("FAIL rst_dout got %h want 000", dataout); else n_pass++;
    n_total++; if (idle !== 1'b0) $display("FAIL rst_idle got %b want 0", idle); else n_pass++;
    reset = 1'b0;
    load(1, 12'h111); load(1, 12'h112); load(1, 12'h113);
    tick(); tick();
    n_total++; if (push !== 1'b1 || dataout !== 12'h111) $display("FAIL mid_push got %b/%h want 1/111", push, dataout); else n_pass++;
    reset = 1'b1; load(0, 12'h0C0);
    tick();
    n_total++; if (pop !== 4'b0000) $display("FAIL midrst_pop got %b want 0000", pop); else n_pass++;
    n_total++; if (push !== 1'b0) $display("FAIL midrst_push got %b want 0", push); else n_pass++;
    n_total++; if (dataout !== 12'h000) $display("FAIL midrst_dout got %h want 000", dataout); else n_pass++;
    n_total++; if (idle !== 1'b0) $display("FAIL midrst_idle got %b want 0", idle); else n_pass++;
    reset = 1'b0;
    tick();
    n_total++; if (pop !== 4'b0001) $display("FAIL post_rst_grant got %b want 0001", pop); else n_pass++;
    tick();
    n_total++; if (pop !== 4'b0010) $display("FAIL post_rst_next got %b want 0010", pop); else n_pass++;
    n_total++; if (push !== 1'b1 || dataout !== 12'h0C0) $display("FAIL post_rst_d0 got %b/%h want 1/0c0", push, dataout); else n_pass++;
    tick();
    n_total++; if (push !== 1'b1 || dataout !== 12'h113) $display("FAIL post_rst_d1 got %b/%h want 1/113", push, dataout); else n_pass++;
    tick();
    n_total++; if (idle !== 1'b1) $display("FAIL post_rst_idle got %b want 1", idle); else n_pass++;
    sb.delete();
  endtask

  task automatic test_single();
    logic [3:0] ep [$];
    logic       ei [$];
    logic [3:0] prev;
    logic [DW-1:0] want;
    apply_reset();
    load(2, 12'h0A1); load(2, 12'h0A2); load(2, 12'h0A3);
    ep = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    ei = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    prev = '0;
    foreach (ep[i]) begin
      tick();
      n_total++; if (pop !== ep[i]) $display("FAIL single_pop[%0d] got %b want %b", i, pop, ep[i]); else n_pass++;
      n_total++; if (push !== (prev != 0)) $display("FAIL single_push[%0d] got %b want %b", i, push, prev != 0); else n_pass++;
      n_total++; if (idle !== ei[i]) $display("FAIL single_idle[%0d] got %b want %b", i, idle, ei[i]); else n_pass++;
      want = last_out;
      if (prev != 0) begin
        if (sb.size() > 0) want = sb.pop_front();
        else $display("FAIL single_sb[%0d] scoreboard empty", i);
      end
      n_total++; if (dataout !== want) $display("FAIL single_dout[%0d] got %h want %h", i, dataout, want); else n_pass++;
      last_out = want;
      prev = ep[i];
    end
  endtask

  task automatic test_rotation();
    logic [3:0] ep [$];
    logic [3:0] prev;
    logic [DW-1:0] want;
    apply_reset();
    for (int r = 0; r < 2; r++)
      for (int v = 0; v < 4; v++)
        for (int b = 0; b < 2; b++) begin
          load(v, 12'(12'h200 + v * 16 + r * 2 + b));
          ep.push_back(4'(1 << v));
        end
    ep.push_back(4'b0000); ep.push_back(4'b0000);
    prev = '0;
    foreach (ep[i]) begin
      tick();
      n_total++; if (pop !== ep[i]) $display("FAIL rot_pop[%0d] got %b want %b", i, pop, ep[i]); else n_pass++;
      n_total++; if (push !== (prev != 0)) $display("FAIL rot_push[%0d] got %b want %b", i, push, prev != 0); else n_pass++;
      want = last_out;
      if (prev != 0) begin
        if (sb.size() > 0) want = sb.pop_front();
        else $display("FAIL rot_sb[%0d] scoreboard empty", i);
      end
      n_total++; if (dataout !== want) $display("FAIL rot_dout[%0d] got %h want %h", i, dataout, want); else n_pass++;
      last_out = want;
      prev = ep[i];
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] ep [$];
    logic       af [$];
    logic [3:0] prev;
    logic [DW-1:0] want;
    apply_reset();
    load(1, 12'h310); load(1, 12'h311); load(2, 12'h320); load(2, 12'h321);
    load(1, 12'h312); load(1, 12'h313); load(1, 12'h314); load(1, 12'h315);
    ep = '{4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0100,
           4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    af = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    prev = '0;
    foreach (ep[i]) begin
      almost_fullFIFO = af[i];
      tick();
      n_total++; if (pop !== ep[i]) $display("FAIL bp_pop[%0d] got %b want %b", i, pop, ep[i]); else n_pass++;
      n_total++; if (push !== (prev != 0)) $display("FAIL bp_push[%0d] got %b want %b", i, push, prev != 0); else n_pass++;
      want = last_out;
      if (prev != 0) begin
        if (sb.size() > 0) want = sb.pop_front();
        else $display("FAIL bp_sb[%0d] scoreboard empty", i);
      end
      n_total++; if (dataout !== want) $display("FAIL bp_dout[%0d] got %h want %h", i, dataout, want); else n_pass++;
      last_out = want;
      prev = ep[i];
    end
    almost_fullFIFO = 1'b0;
  endtask

  task automatic test_active();
    logic [3:0] ep [$];
    logic       act [$];
    logic       ei [$];
    logic [3:0] prev;
    logic [DW-1:0] want;
    apply_reset();
    for (int v = 0; v < 4; v++) begin
      load(v, 12'(12'h400 + v * 16));
      load(v, 12'(12'h401 + v * 16));
    end
    ep  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010,
            4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    act = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
            1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    ei  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    prev = '0;
    foreach (ep[i]) begin
      active = act[i];
      tick();
      n_total++; if (pop !== ep[i]) $display("FAIL act_pop[%0d] got %b want %b", i, pop, ep[i]); else n_pass++;
      n_total++; if (push !== (prev != 0)) $display("FAIL act_push[%0d] got %b want %b", i, push, prev != 0); else n_pass++;
      n_total++; if (idle !== ei[i]) $display("FAIL act_idle[%0d] got %b want %b", i, idle, ei[i]); else n_pass++;
      want = last_out;
      if (prev != 0) begin
        if (sb.size() > 0) want = sb.pop_front();
        else $display("FAIL act_sb[%0d] scoreboard empty", i);
      end
      n_total++; if (dataout !== want) $display("FAIL act_dout[%0d] got %h want %h", i, dataout, want); else n_pass++;
      last_out = want;
      prev = ep[i];
    end
    active = 1'b1;
  endtask

  task automatic test_empty_race();
    logic [3:0] ep [$];
    logic [3:0] prev;
    logic [DW-1:0] want;
    apply_reset();
    load(3, 12'h5A3);
    ep = '{4'b1000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
    prev = '0;
    foreach (ep[i]) begin
      if (i == 1) begin
        load(0, 12'h501); load(0, 12'h502); load(0, 12'h503);
      end
      tick();
      n_total++; if (pop !== ep[i]) $display("FAIL race_pop[%0d] got %b want %b", i, pop, ep[i]); else n_pass++;
      n_total++; if (push !== (prev != 0)) $display("FAIL race_push[%0d] got %b want %b", i, push, prev != 0); else n_pass++;
      want = last_out;
      if (prev != 0) begin
        if (sb.size() > 0) want = sb.pop_front();
        else $display("FAIL race_sb[%0d] scoreboard empty", i);
      end
      n_total++; if (dataout !== want) $display("FAIL race_dout[%0d] got %h want %h", i, dataout, want); else n_pass++;
      last_out = want;
      prev = ep[i];
    end
    n_total++; if (sb.size() !== 0) $display("FAIL race_leftover got %0d want 0", sb.size()); else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    active = 1'b0;
    almost_fullFIFO = 1'b0;
    last_out = '0;
    clear_model();
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_active();
    test_empty_race();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
